qbus_slave: RTL and testbench

QBUS_SLAVE -- requirements
Module: qbus_slave

---
 rtl/qbus_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_qbus_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_slave.sv
// Q-bus slave for an 8-word register block in the I/O page. Bus controls are
// synchronized, then a single FSM sequences DATI/DATO(B)/DATIO through the Am2908 transceivers.
module qbus_slave #(
  parameter logic [12:0] BASE_ADDR = 13'o14400
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RSYNC,
  input  logic        RDIN,
  input  logic        RDOUT,
  input  logic        RINIT,
  inout  wire  [21:0] ZDAL,
  input  logic        ZBS7,
  input  logic        ZWTBT,
  output logic        DALtx,
  output logic        DALst,
  output logic        DALbe_L,
  output logic        TRPLY,
  output logic [2:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic [1:0]  reg_bsel,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEL       = 3'd1,
    RD_FETCH  = 3'd2,
    RD_DRIVE  = 3'd3,
    RD_LATCH  = 3'd4,
    RD_EN     = 3'd5,
    REPLY     = 3'd6,
    WAIT_SYNC = 3'd7
  } state_t;

  state_t state, state_n;

  logic [3:0] sync1, sync2;
  logic       rsync_s, rdin_s, rdout_s, rinit_s;
  logic       rsync_d;
  logic [1:0] warm;
  logic       armed;

  logic        tx_n, st_n, be_n, trply_n, rd_n, wr_n;
  logic [2:0]  addr_n;
  logic [15:0] wdata_n;
  logic [1:0]  bsel_n;
  logic        a0, a0_n;
  logic        is_read, is_read_n;
  logic [15:0] rd_data, rd_data_n;

  logic sync_rise, sel_hit, strobe;
  wire  unused_dal = ^ZDAL[21:16];

  assign {rsync_s, rdin_s, rdout_s, rinit_s} = sync2;
  assign state_dbg = state;

  // Upper DAL bits are never driven high; the bus is released whenever DALtx is low.
  assign ZDAL = DALtx ? {6'b0, rd_data} : {22{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 4'b0;
      sync2   <= 4'b0;
      rsync_d <= 1'b0;
    end else begin
      sync1   <= {RSYNC, RDIN, RDOUT, RINIT};
      sync2   <= sync1;
      rsync_d <= rsync_s;
    end
  end

  // The synchronizers read 0 straight out of reset whatever RSYNC is doing, so
  // arming waits until they carry real samples and RSYNC is genuinely low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (warm == 2'd3 && !rsync_s) armed <= 1'b1;
    end
  end

  assign sync_rise = armed && rsync_s && !rsync_d;
  assign sel_hit   = ZBS7 && (ZDAL[12:4] == BASE_ADDR[12:4]);
  assign strobe    = is_read ? rdin_s : rdout_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      DALtx     <= 1'b0;
      DALst     <= 1'b0;
      DALbe_L   <= 1'b1;
      TRPLY     <= 1'b0;
      reg_addr  <= 3'd0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= 16'd0;
      reg_bsel  <= 2'd0;
      a0        <= 1'b0;
      is_read   <= 1'b0;
      rd_data   <= 16'd0;
    end else begin
      state     <= state_n;
      DALtx     <= tx_n;
      DALst     <= st_n;
      DALbe_L   <= be_n;
      TRPLY     <= trply_n;
      reg_addr  <= addr_n;
      reg_rd    <= rd_n;
      reg_wr    <= wr_n;
      reg_wdata <= wdata_n;
      reg_bsel  <= bsel_n;
      a0        <= a0_n;
      is_read   <= is_read_n;
      rd_data   <= rd_data_n;
    end
  end

  // Reply handshake: TRPLY rises once the cycle's work is done (data latched and
  // enabled for a read, strobe issued for a write) and stays high until the
  // master drops the active strobe; the transceiver is turned around one cycle
  // after TRPLY falls so the next DOUT in the same SYNC sees a released bus.
  always_comb begin
    state_n   = state;
    tx_n      = DALtx;
    st_n      = 1'b0;
    be_n      = DALbe_L;
    trply_n   = TRPLY;
    addr_n    = reg_addr;
    rd_n      = 1'b0;
    wr_n      = 1'b0;
    wdata_n   = reg_wdata;
    bsel_n    = reg_bsel;
    a0_n      = a0;
    is_read_n = is_read;
    rd_data_n = rd_data;

    if (rinit_s) begin
      state_n   = IDLE;
      tx_n      = 1'b0;
      be_n      = 1'b1;
      trply_n   = 1'b0;
      addr_n    = 3'd0;
      wdata_n   = 16'd0;
      bsel_n    = 2'd0;
      a0_n      = 1'b0;
      is_read_n = 1'b0;
    end else if (state != IDLE && state != WAIT_SYNC && !rsync_s) begin
      state_n = IDLE;
      tx_n    = 1'b0;
      be_n    = 1'b1;
      trply_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_n    = 1'b0;
          be_n    = 1'b1;
          trply_n = 1'b0;
          if (sync_rise) begin
            addr_n  = ZDAL[3:1];
            a0_n    = ZDAL[0];
            state_n = sel_hit ? SEL : WAIT_SYNC;
          end
        end
        SEL: begin
          if (rdin_s) begin
            rd_n      = 1'b1;
            is_read_n = 1'b1;
            state_n   = RD_FETCH;
          end else if (rdout_s) begin
            wdata_n   = ZDAL[15:0];
            bsel_n    = ZWTBT ? (a0 ? 2'b10 : 2'b01) : 2'b11;
            wr_n      = 1'b1;
            trply_n   = 1'b1;
            is_read_n = 1'b0;
            state_n   = REPLY;
          end
        end
        RD_FETCH: begin
          rd_data_n = reg_rdata;
          tx_n      = 1'b1;
          state_n   = RD_DRIVE;
        end
        RD_DRIVE: begin
          st_n    = 1'b1;
          state_n = RD_LATCH;
        end
        RD_LATCH: begin
          be_n    = 1'b0;
          state_n = RD_EN;
        end
        RD_EN: begin
          trply_n = 1'b1;
          state_n = REPLY;
        end
        REPLY: begin
          if (TRPLY) begin
            if (!strobe) begin
              trply_n = 1'b0;
              be_n    = 1'b1;
            end
          end else begin
            tx_n    = 1'b0;
            state_n = rsync_s ? SEL : IDLE;
          end
        end
        WAIT_SYNC: begin
          tx_n    = 1'b0;
          be_n    = 1'b1;
          trply_n = 1'b0;
          if (!rsync_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qbus_slave.sv
// Bench for qbus_slave: directed Q-bus cycles, expected register strobes and
// replies queued at issue time and matched by an independent output monitor.
module tb_qbus_slave;

  localparam logic [2:0] S_IDLE = 3'd0, S_RD_DRIVE = 3'd3, S_WAIT = 3'd7;
  localparam logic [2:0] K_RD = 3'd1, K_WR = 3'd2, K_RR = 3'd3, K_WRR = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RINIT = 1'b0;
  logic        ZBS7 = 1'b0, ZWTBT = 1'b0;
  logic [21:0] tb_dal = 22'd0;
  logic        tb_dal_en = 1'b0;
  wire  [21:0] ZDAL;
  logic        DALtx, DALst, DALbe_L, TRPLY;
  logic [2:0]  reg_addr;
  logic        reg_rd, reg_wr;
  logic [15:0] reg_rdata, reg_wdata;
  logic [1:0]  reg_bsel;
  logic [2:0]  state_dbg;

  logic [15:0] mem [8];
  logic [39:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign ZDAL      = tb_dal_en ? tb_dal : {22{1'bz}};
  assign reg_rdata = mem[reg_addr];

  qbus_slave dut (
    .clk(clk), .reset_n(reset_n), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
    .RINIT(RINIT), .ZDAL(ZDAL), .ZBS7(ZBS7), .ZWTBT(ZWTBT), .DALtx(DALtx),
    .DALst(DALst), .DALbe_L(DALbe_L), .TRPLY(TRPLY), .reg_addr(reg_addr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_bsel(reg_bsel), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [39:0] pk(input logic [2:0] k, input logic [2:0] a,
                                     input logic [1:0] b, input logic be,
                                     input logic [1:0] ns, input logic [2:0] lat,
                                     input logic [21:0] d);
    return {k, a, b, be, ns, lat, 4'b0, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard
  task automatic report(input logic [39:0] got);
    logic [39:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %h expected none", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL event: got %h expected %h", got, e);
      end
    end
  endtask

  // monitor
  initial begin
    logic [2:0] since_rd;
    logic [1:0] nst;
    logic       trply_prev;
    since_rd = 3'd7;
    nst = 2'd0;
    trply_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (reg_rd && reg_wr) chk("rd_wr_same_cycle", 32'd1, 32'd0);
        if (reg_rd) begin
          since_rd = 3'd0;
          nst = 2'd0;
          report(pk(K_RD, reg_addr, 2'b00, 1'b0, 2'd0, 3'd0, 22'd0));
        end else begin
          if (since_rd != 3'd7) since_rd++;
          if (DALst && nst != 2'd3) nst++;
        end
        if (reg_wr)
          report(pk(K_WR, reg_addr, reg_bsel, 1'b0, 2'd0, 3'd0, {6'b0, reg_wdata}));
        if (TRPLY && !trply_prev) begin
          if (DALtx) report(pk(K_RR, 3'd0, 2'b00, DALbe_L, nst, since_rd, ZDAL));
          else       report(pk(K_WRR, 3'd0, 2'b00, DALbe_L, 2'd0, 3'd0, {21'b0, DALtx}));
        end
        trply_prev = TRPLY;
      end else begin
        trply_prev = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_trply(input logic v, input string name);
    int n = 0;
    while (TRPLY !== v && n < 40) begin cyc(1); n++; end
    chk(name, {31'b0, TRPLY}, {31'b0, v});
  endtask

  task automatic wait_tx_off(input string name);
    int n = 0;
    while (DALtx !== 1'b0 && n < 40) begin cyc(1); n++; end
    chk(name, {31'b0, DALtx}, 32'd0);
  endtask

  task automatic addr_phase(input logic [21:0] a, input logic bs7, input logic wtbt);
    tb_dal = a; tb_dal_en = 1'b1; ZBS7 = bs7; ZWTBT = wtbt;
    cyc(1);
    RSYNC = 1'b1;
    cyc(4);
    tb_dal_en = 1'b0; ZBS7 = 1'b0;
  endtask

  task automatic end_sync(input string name);
    RSYNC = 1'b0; ZWTBT = 1'b0;
    cyc(4);
    chk(name, {29'b0, state_dbg}, {29'b0, S_IDLE});
  endtask

  task automatic do_din(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back(pk(K_RD, a, 2'b00, 1'b0, 2'd0, 3'd0, 22'd0));
    exp_q.push_back(pk(K_RR, 3'd0, 2'b00, 1'b0, 2'd1, 3'd4, {6'b0, d}));
    RDIN = 1'b1;
    wait_trply(1'b1, "din_trply_rise");
    RDIN = 1'b0;
    wait_trply(1'b0, "din_trply_fall");
    wait_tx_off("din_daltx_off");
  endtask

  task automatic do_dout(input logic [2:0] a, input logic [1:0] b, input logic [15:0] d);
    exp_q.push_back(pk(K_WR, a, b, 1'b0, 2'd0, 3'd0, {6'b0, d}));
    exp_q.push_back(pk(K_WRR, 3'd0, 2'b00, 1'b1, 2'd0, 3'd0, 22'd0));
    chk("dout_bus_free", {31'b0, DALtx}, 32'd0);
    tb_dal = {6'b0, d}; tb_dal_en = 1'b1;
    RDOUT = 1'b1;
    wait_trply(1'b1, "dout_trply_rise");
    RDOUT = 1'b0;
    wait_trply(1'b0, "dout_trply_fall");
    tb_dal_en = 1'b0;
  endtask

  task automatic dati_406(input string name);
    addr_phase(22'o774406, 1'b1, 1'b0);
    do_din(3'd3, 16'o123456);
    end_sync(name);
  endtask

  initial begin
    mem[0] = 16'o000777; mem[1] = 16'o000001; mem[2] = 16'o000002;
    mem[3] = 16'o123456; mem[4] = 16'o000004; mem[5] = 16'o000005;
    mem[6] = 16'o000006; mem[7] = 16'o000007;

    // reset with SYNC already high and a matching address on the bus
    reset_n = 1'b0;
    RSYNC = 1'b1; tb_dal = 22'o774400; tb_dal_en = 1'b1; ZBS7 = 1'b1;
    cyc(3);
    chk("rst_trply", {31'b0, TRPLY}, 32'd0);
    chk("rst_daltx", {31'b0, DALtx}, 32'd0);
    chk("rst_dalst", {31'b0, DALst}, 32'd0);
    chk("rst_dalbe", {31'b0, DALbe_L}, 32'd1);
    chk("rst_rd_wr", {30'b0, reg_rd, reg_wr}, 32'd0);
    chk("rst_addr", {29'b0, reg_addr}, 32'd0);
    chk("rst_wdata", {16'b0, reg_wdata}, 32'd0);
    chk("rst_bsel", {30'b0, reg_bsel}, 32'd0);
    chk("rst_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    reset_n = 1'b1;
    cyc(10);
    chk("post_rst_no_start", {29'b0, state_dbg}, {29'b0, S_IDLE});
    chk("post_rst_trply", {31'b0, TRPLY}, 32'd0);
    RSYNC = 1'b0; tb_dal_en = 1'b0; ZBS7 = 1'b0;
    cyc(4);

    // DATI 774406
    dati_406("dati_end_idle");

    // DATO 774412, word
    addr_phase(22'o774412, 1'b1, 1'b0);
    do_dout(3'd5, 2'b11, 16'o177777);
    end_sync("dato_end_idle");

    // DATOB 774413 high byte, then 774412 low byte
    addr_phase(22'o774413, 1'b1, 1'b1);
    do_dout(3'd5, 2'b10, 16'o052000);
    end_sync("datob_hi_end_idle");
    addr_phase(22'o774412, 1'b1, 1'b1);
    do_dout(3'd5, 2'b01, 16'o000377);
    end_sync("datob_lo_end_idle");

    // non-matching address and BS7 low: strobes must be ignored
    addr_phase(22'o774500, 1'b1, 1'b0);
    chk("nomatch_wait", {29'b0, state_dbg}, {29'b0, S_WAIT});
    RDIN = 1'b1; cyc(4);
    chk("nomatch_trply", {31'b0, TRPLY}, 32'd0);
    chk("nomatch_daltx", {31'b0, DALtx}, 32'd0);
    RDIN = 1'b0;
    end_sync("nomatch_end_idle");
    addr_phase(22'o174400, 1'b0, 1'b0);
    chk("nobs7_wait", {29'b0, state_dbg}, {29'b0, S_WAIT});
    RDOUT = 1'b1; tb_dal = 22'o000123; tb_dal_en = 1'b1; cyc(4);
    chk("nobs7_trply", {31'b0, TRPLY}, 32'd0);
    RDOUT = 1'b0; tb_dal_en = 1'b0;
    end_sync("nobs7_end_idle");

    // DATIO 774400: read then write in one SYNC
    addr_phase(22'o774400, 1'b1, 1'b0);
    do_din(3'd0, 16'o000777);
    do_dout(3'd0, 2'b11, 16'o012345);
    end_sync("datio_end_idle");

    // SYNC dropped while in RD_DRIVE
    addr_phase(22'o774406, 1'b1, 1'b0);
    exp_q.push_back(pk(K_RD, 3'd3, 2'b00, 1'b0, 2'd0, 3'd0, 22'd0));
    RDIN = 1'b1;
    cyc(2);
    RSYNC = 1'b0;
    cyc(2);
    chk("abort_in_rd_drive", {29'b0, state_dbg}, {29'b0, S_RD_DRIVE});
    cyc(1);
    chk("abort_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    chk("abort_daltx", {31'b0, DALtx}, 32'd0);
    chk("abort_dalbe", {31'b0, DALbe_L}, 32'd1);
    chk("abort_trply", {31'b0, TRPLY}, 32'd0);
    RDIN = 1'b0;
    cyc(4);
    dati_406("after_abort_end_idle");

    // INIT pulsed during REPLY
    addr_phase(22'o774406, 1'b1, 1'b0);
    exp_q.push_back(pk(K_RD, 3'd3, 2'b00, 1'b0, 2'd0, 3'd0, 22'd0));
    exp_q.push_back(pk(K_RR, 3'd0, 2'b00, 1'b0, 2'd1, 3'd4, {6'b0, 16'o123456}));
    RDIN = 1'b1;
    wait_trply(1'b1, "init_case_trply");
    RINIT = 1'b1;
    cyc(3);
    chk("init_trply", {31'b0, TRPLY}, 32'd0);
    chk("init_dalbe", {31'b0, DALbe_L}, 32'd1);
    chk("init_daltx", {31'b0, DALtx}, 32'd0);
    chk("init_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    chk("init_addr", {29'b0, reg_addr}, 32'd0);
    RDIN = 1'b0; RSYNC = 1'b0;
    cyc(3);
    RINIT = 1'b0;
    cyc(3);
    dati_406("after_init_end_idle");

    cyc(4);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
